led_matrix_scan_ctrl: RTL and testbench



---
 rtl/led_matrix_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_led_matrix_scan_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan_ctrl.sv
// Row-multiplexed LED matrix driver with a double-buffered frame store and tear-free swaps.
// Define MATRIX_PWM_EN to add a 4-bit brightness input that gates the columns during SHOW.
module led_matrix_scan_ctrl #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROW_AW     = 3,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned BLANK_CYC  = 4,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ROW_AW-1:0] wr_row,
    input  logic [COLS-1:0]   wr_data,
    input  logic              swap_req,
`ifdef MATRIX_PWM_EN
    input  logic [3:0]        brightness,
`endif
    output logic              swap_ack,
    output logic              frame_start,
    output logic [ROWS-1:0]   output_row,
    output logic [COLS-1:0]   output_col
);

    localparam int unsigned CntMax  = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CntW    = $clog2(CntMax + 1);
    localparam int unsigned RowIdxW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CntW-1:0]   ShowLast  = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0]   BlankLast = CntW'(BLANK_CYC - 1);
    localparam logic [ROW_AW-1:0] RowLast   = ROW_AW'(ROWS - 1);
    localparam logic [ROWS-1:0]   RowOff    = {ROWS{ACTIVE_LOW != 0}};
    localparam logic [COLS-1:0]   ColOff    = {COLS{ACTIVE_LOW != 0}};

    typedef enum logic [0:0] {StBlank, StShow} state_e;

    state_e            state_q, state_d;
    logic [ROW_AW-1:0] row_q, row_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              front_sel_q, front_sel_d;
    logic              pending_q, pending_d;
    logic [COLS-1:0]   mem_q [2][ROWS];
    logic [COLS-1:0]   mem_d [2][ROWS];
    logic              swap_ack_q, swap_ack_d;
    logic              frame_start_q, frame_start_d;
    logic [ROWS-1:0]   out_row_q, out_row_d;
    logic [COLS-1:0]   out_col_q, out_col_d;

    logic               boundary, do_swap, wr_ok;
    logic [RowIdxW-1:0] wr_idx, rd_idx;
    logic [COLS-1:0]    show_data;
    logic               col_gate;
`ifdef MATRIX_PWM_EN
    logic [3:0]         pwm_q, pwm_d;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d = StShow;
                    cnt_d   = '0;
                end
            end
            StShow: begin
                if (cnt_q == ShowLast) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    row_d   = (row_q == RowLast) ? '0 : row_q + 1'b1;
                end
            end
            default: begin
                state_d = StBlank;
                cnt_d   = '0;
            end
        endcase

        // Boundary = last SHOW cycle of the last row; a request arriving right here still counts.
        boundary    = (state_q == StShow) && (row_q == RowLast) && (cnt_q == ShowLast);
        do_swap     = boundary && (pending_q || swap_req);
        front_sel_d = front_sel_q ^ do_swap;
        pending_d   = (pending_q || swap_req) && !do_swap;
        swap_ack_d  = do_swap;

        // Writes target the pre-swap back buffer even in the swapping cycle.
        mem_d  = mem_q;
        wr_ok  = wr_en && (32'(wr_row) < ROWS);
        wr_idx = RowIdxW'(wr_row);
        if (wr_ok) begin
            mem_d[~front_sel_q][wr_idx] = wr_data;
        end

        rd_idx        = RowIdxW'(row_d);
        show_data     = mem_q[front_sel_d][rd_idx];
        frame_start_d = (state_d == StShow) && (cnt_d == '0) && (row_d == '0);

`ifdef MATRIX_PWM_EN
        pwm_d    = (state_d == StShow && state_q == StShow) ? pwm_q + 4'd1 : 4'd0;
        col_gate = (pwm_d <= brightness);
`else
        col_gate = 1'b1;
`endif

        if (state_d == StShow) begin
            out_row_d = (ROWS'(1) << row_d) ^ RowOff;
            out_col_d = col_gate ? (show_data ^ ColOff) : ColOff;
        end else begin
            out_row_d = RowOff;
            out_col_d = ColOff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBlank;
            row_q         <= '0;
            cnt_q         <= '0;
            front_sel_q   <= 1'b0;
            pending_q     <= 1'b0;
            mem_q         <= '{default: '0};
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            out_row_q     <= RowOff;
            out_col_q     <= ColOff;
`ifdef MATRIX_PWM_EN
            pwm_q         <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            cnt_q         <= cnt_d;
            front_sel_q   <= front_sel_d;
            pending_q     <= pending_d;
            mem_q         <= mem_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
            out_row_q     <= out_row_d;
            out_col_q     <= out_col_d;
`ifdef MATRIX_PWM_EN
            pwm_q         <= pwm_d;
`endif
        end
    end

    assign swap_ack    = swap_ack_q;
    assign frame_start = frame_start_q;
    assign output_row  = out_row_q;
    assign output_col  = out_col_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Self-checking bench for led_matrix_scan_ctrl: a frame/row arithmetic model is compared every cycle.
// Define MATRIX_PWM_EN to also exercise the brightness gating.
module tb_led_matrix_scan_ctrl;

    localparam int ROWS       = 8;
    localparam int COLS       = 16;
    localparam int ROW_AW     = 4;
    localparam int SCAN_DIV   = 8;
    localparam int BLANK_CYC  = 2;
    localparam int ACTIVE_LOW = 1;
    localparam int P          = BLANK_CYC + SCAN_DIV;
    localparam int F          = ROWS * P;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ROW_AW-1:0] wr_row = '0;
    logic [COLS-1:0]   wr_data = '0;
    logic              swap_req = 1'b0;
    logic [3:0]        brightness = 4'd15;
    logic              swap_ack, frame_start;
    logic [ROWS-1:0]   output_row;
    logic [COLS-1:0]   output_col;

    led_matrix_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .ROW_AW(ROW_AW), .SCAN_DIV(SCAN_DIV),
        .BLANK_CYC(BLANK_CYC), .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_row(wr_row),
        .wr_data(wr_data),
        .swap_req(swap_req),
`ifdef MATRIX_PWM_EN
        .brightness(brightness),
`endif
        .swap_ack(swap_ack),
        .frame_start(frame_start),
        .output_row(output_row),
        .output_col(output_col)
    );

    always #5 clk = ~clk;

    // Reference model: front/back held as plain row arrays, swapped by copying contents.
    logic [COLS-1:0] m_front [ROWS];
    logic [COLS-1:0] m_back  [ROWS];
    bit              m_pend, m_ack_next;
    int              t;
    int              checks = 0;
    int              errors = 0;
    int              n_ack;
    int              s_t;
    logic [ROWS-1:0] s_row;
    logic [COLS-1:0] s_col;
    logic            s_fs, s_ack;

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) begin
            m_front[r] = '0;
            m_back[r]  = '0;
        end
        m_pend = 0;
        m_ack_next = 0;
        t = 0;
    endtask

    task automatic clear_inputs();
        wr_en = 1'b0;
        wr_row = '0;
        wr_data = '0;
        swap_req = 1'b0;
    endtask

    // One clock: compare DUT outputs with the model at negedge, then apply this cycle's inputs.
    task automatic tick();
        int ph, fr, r;
        logic [ROWS-1:0] er;
        logic [COLS-1:0] ec;
        logic [COLS-1:0] tmp;
        @(negedge clk);
        ph = t % P;
        fr = t % F;
        r  = (t / P) % ROWS;
        er = '1;
        ec = '1;
        if (ph >= BLANK_CYC) begin
            er = ~(ROWS'(1) << r);
            ec = ~m_front[r];
            if (((ph - BLANK_CYC) % 16) > int'(brightness)) ec = '1;
        end
        s_t = t; s_row = output_row; s_col = output_col; s_fs = frame_start; s_ack = swap_ack;
        checks += 4;
        if (output_row !== er) begin
            errors++; $display("FAIL row t=%0d: got %h want %h", t, output_row, er);
        end
        if (output_col !== ec) begin
            errors++; $display("FAIL col t=%0d: got %h want %h", t, output_col, ec);
        end
        if (frame_start !== (fr == BLANK_CYC)) begin
            errors++; $display("FAIL frame_start t=%0d: got %b want %b", t, frame_start, fr == BLANK_CYC);
        end
        if (swap_ack !== m_ack_next) begin
            errors++; $display("FAIL swap_ack t=%0d: got %b want %b", t, swap_ack, m_ack_next);
        end
        if (swap_ack === 1'b1) n_ack++;
        m_ack_next = 0;
        if (wr_en && int'(wr_row) < ROWS) m_back[int'(wr_row)] = wr_data;
        if (fr == F - 1 && (m_pend || swap_req)) begin
            for (int i = 0; i < ROWS; i++) begin
                tmp = m_front[i]; m_front[i] = m_back[i]; m_back[i] = tmp;
            end
            m_pend = 0;
            m_ack_next = 1;
        end else if (swap_req) begin
            m_pend = 1;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run_to(input int fr);
        for (int i = 0; i < F && (t % F) != fr; i++) tick();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (output_row !== 8'hFF || output_col !== 16'hFFFF || swap_ack !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL in_reset: got row=%h col=%h ack=%b fs=%b want FF FFFF 0 0",
                     output_row, output_col, swap_ack, frame_start);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        int n_fs = 0;
        do_reset();
        for (int i = 0; i < 2 * F + 3; i++) begin
            tick();
            if (s_fs === 1'b1) n_fs++;
            if (s_t == 2) begin
                checks++;
                if (s_row !== 8'hFE || s_fs !== 1'b1) begin
                    errors++; $display("FAIL first_lit: got row=%h fs=%b want FE 1", s_row, s_fs);
                end
            end
            if (s_t == 12) begin
                checks++;
                if (s_row !== 8'hFD) begin
                    errors++; $display("FAIL row1_at_12: got %h want FD", s_row);
                end
            end
        end
        checks++;
        if (n_fs != 3) begin
            errors++; $display("FAIL frame_start_count: got %0d want 3", n_fs);
        end
    endtask

    task automatic test_write_no_swap();
        int bad = 0;
        wr_en = 1'b1; wr_row = 4'd3; wr_data = 16'h8001;
        tick();
        clear_inputs();
        for (int i = 0; i < F + P; i++) begin
            tick();
            if (s_col !== 16'hFFFF) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL no_swap_display: got %0d lit cycles want 0", bad);
        end
    endtask

    task automatic test_swap();
        int hits = 0;
        n_ack = 0;
        run_to(40);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        run_to(0);
        for (int i = 0; i < F; i++) begin
            tick();
            if ((s_t % F) >= 3 * P + BLANK_CYC && (s_t % F) < 4 * P) begin
                hits++;
                checks++;
                if (s_row !== 8'hF7 || s_col !== 16'h7FFE) begin
                    errors++; $display("FAIL swap_row3: got row=%h col=%h want F7 7FFE", s_row, s_col);
                end
            end
        end
        checks += 2;
        if (n_ack != 1) begin
            errors++; $display("FAIL swap_ack_count: got %0d want 1", n_ack);
        end
        if (hits != SCAN_DIV) begin
            errors++; $display("FAIL swap_row3_window: got %0d want %0d", hits, SCAN_DIV);
        end
    endtask

    task automatic test_multi_swap();
        n_ack = 0;
        run_to(10);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        run_to(30);
        swap_req = 1'b1; wr_en = 1'b1; wr_row = 4'd9; wr_data = 16'hFFFF; tick(); clear_inputs();
        run_to(50);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        run_to(0);
        for (int i = 0; i < F; i++) tick();
        checks++;
        if (n_ack != 1) begin
            errors++; $display("FAIL multi_swap_ack_count: got %0d want 1", n_ack);
        end
    endtask

    task automatic test_boundary_write();
        run_to(F - 1);
        wr_en = 1'b1; wr_row = 4'd0; wr_data = 16'h00FF; swap_req = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < P; i++) begin
            tick();
            if ((s_t % F) >= BLANK_CYC) begin
                checks++;
                if (s_row !== 8'hFE || s_col !== 16'hFF00) begin
                    errors++; $display("FAIL boundary_write: got row=%h col=%h want FE FF00", s_row, s_col);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 5 * F; i++) begin
            wr_en    = ($urandom % 4) == 0;
            wr_row   = ROW_AW'($urandom_range(0, 11));
            wr_data  = COLS'($urandom);
            swap_req = ($urandom % 40) == 0;
            tick();
        end
        clear_inputs();
        for (int i = 0; i < F; i++) tick();
    endtask

    task automatic test_mid_reset();
        for (int r = 0; r < ROWS; r++) begin
            wr_en = 1'b1; wr_row = ROW_AW'(r); wr_data = COLS'($urandom) | 16'h0001;
            tick();
        end
        clear_inputs();
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        run_to(0);
        run_to(3 * P + 4);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (output_row !== 8'hFF || output_col !== 16'hFFFF || swap_ack !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got row=%h col=%h ack=%b fs=%b want FF FFFF 0 0",
                     output_row, output_col, swap_ack, frame_start);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        for (int i = 0; i < 2 * F; i++) tick();
    endtask

`ifdef MATRIX_PWM_EN
    task automatic test_pwm();
        brightness = 4'd3;
        do_reset();
        wr_en = 1'b1; wr_row = 4'd0; wr_data = 16'hFFFF; swap_req = 1'b1;
        tick();
        clear_inputs();
        run_to(0);
        for (int i = 0; i < P; i++) begin
            tick();
            if (s_t % F >= BLANK_CYC) begin
                checks++;
                if (s_row !== 8'hFE ||
                    s_col !== ((s_t % F) - BLANK_CYC <= 3 ? 16'h0000 : 16'hFFFF)) begin
                    errors++; $display("FAIL pwm t=%0d: got row=%h col=%h", s_t, s_row, s_col);
                end
            end
        end
        for (int i = 0; i < F; i++) tick();
    endtask
`endif

    initial begin
        model_reset();
        n_ack = 0;
        test_reset();
        test_write_no_swap();
        test_swap();
        test_multi_swap();
        test_boundary_write();
        test_random();
        test_mid_reset();
`ifdef MATRIX_PWM_EN
        test_pwm();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
